// File: rtl/counter_display_if.sv
// counter_display_if: binary count in, 7-segment pins and conversion status out
interface counter_display_if;
    logic [6:0] value;
    logic [6:0] seg;
    logic [2:0] an;
    logic busy;
    logic err;
    modport master(output value, input seg, an, busy, err);
    modport slave(input value, output seg, an, busy, err);
endinterface

// File: rtl/counter_display_driver.sv
// counter_display_driver: double-dabble BCD conversion feeding a multiplexed 3-digit 7-segment scan
module counter_display_driver #(
    parameter int SCAN_DIV = 4,
    parameter int MAX_VALUE = 100
) (
    input logic clk,
    input logic reset,
    counter_display_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, CONVERT = 2'd1, LATCH = 2'd2;
    localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [7:0] MAXV = 8'(MAX_VALUE);
    logic [1:0] state;
    logic [6:0] snap;
    logic pending;
    logic [18:0] sr;
    logic [2:0] step;
    logic [3:0] h, t, o;
    logic err_q;
    logic [1:0] idx;
    logic [PW-1:0] presc;
    logic [2:0] an_q;
    logic [6:0] seg_q;
    logic [18:0] sr_adj;
    logic wrap;
    logic [1:0] idx_next;
    logic [3:0] digit;
    logic blank;
    logic [6:0] seg_next;
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0: seg_code = 7'h3F;
            4'd1: seg_code = 7'h06;
            4'd2: seg_code = 7'h5B;
            4'd3: seg_code = 7'h4F;
            4'd4: seg_code = 7'h66;
            4'd5: seg_code = 7'h6D;
            4'd6: seg_code = 7'h7D;
            4'd7: seg_code = 7'h07;
            4'd8: seg_code = 7'h7F;
            4'd9: seg_code = 7'h6F;
            default: seg_code = 7'h00;
        endcase
    endfunction
    always_comb begin
        sr_adj = {sr[18:15] + (sr[18:15] >= 4'd5 ? 4'd3 : 4'd0),
                  sr[14:11] + (sr[14:11] >= 4'd5 ? 4'd3 : 4'd0),
                  sr[10:7] + (sr[10:7] >= 4'd5 ? 4'd3 : 4'd0),
                  sr[6:0]};
        wrap = presc == PW'(SCAN_DIV - 1);
        idx_next = wrap ? (idx == 2'd2 ? 2'd0 : idx + 2'd1) : idx;
        digit = idx_next == 2'd0 ? o : idx_next == 2'd1 ? t : h;
        blank = (idx_next == 2'd2 && h == 4'd0) || (idx_next == 2'd1 && h == 4'd0 && t == 4'd0);
        seg_next = err_q ? 7'h40 : blank ? 7'h00 : seg_code(digit);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            snap <= '0;
            pending <= 1'b1;
            sr <= '0;
            step <= '0;
            h <= '0;
            t <= '0;
            o <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pending || bus.value != snap) begin
                    snap <= bus.value;
                    sr <= {12'b0, bus.value};
                    step <= '0;
                    pending <= 1'b0;
                    state <= CONVERT;
                end
                CONVERT: begin
                    sr <= {sr_adj[17:0], 1'b0};
                    step <= step + 3'd1;
                    state <= step == 3'd6 ? LATCH : CONVERT;
                end
                default: begin
                    h <= sr[18:15];
                    t <= sr[14:11];
                    o <= sr[10:7];
                    err_q <= {1'b0, snap} > MAXV;
                    state <= IDLE;
                end
            endcase
        end
    end
    // an and seg both follow idx_next so the enabled digit and its pattern change together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
            presc <= '0;
            an_q <= 3'b001;
            seg_q <= 7'h3F;
        end else begin
            presc <= wrap ? '0 : presc + 1'b1;
            idx <= idx_next;
            an_q <= 3'b001 << idx_next;
            seg_q <= seg_next;
        end
    end
    assign bus.seg = seg_q;
    assign bus.an = an_q;
    assign bus.busy = state != IDLE;
    assign bus.err = err_q;
endmodule

// File: tb/tb_counter_display_driver.sv
// tb_counter_display_driver: random and directed stimulus against an arithmetic display model
module tb_counter_display_driver;
    localparam int SCAN_DIV = 4;
    localparam int MAX_VALUE = 100;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    counter_display_if bus();
    counter_display_driver #(.SCAN_DIV(SCAN_DIV), .MAX_VALUE(MAX_VALUE)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );
    int checks = 0;
    int errors = 0;
    int convs = 0;
    logic prev_busy = 1'b0;
    logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int k, busy_cnt, snap, disp_val;
    bit pending, disp_err;
    logic [2:0] an_exp;
    logic [6:0] seg_exp;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [6:0] shown(input int pos, input int v, input bit e);
        int hd, td, od;
        hd = v / 100;
        td = (v / 10) % 10;
        od = v % 10;
        if (e) return 7'h40;
        if (pos == 0) return codes[od];
        if (pos == 1) return (hd == 0 && td == 0) ? 7'h00 : codes[td];
        return hd == 0 ? 7'h00 : codes[hd];
    endfunction
    // Model: a conversion is an 8-edge busy window after sampling; display value/scan from plain arithmetic
    always @(posedge clk or posedge reset) begin : model
        int pos;
        if (reset) begin
            k = 0;
            busy_cnt = 0;
            snap = 0;
            pending = 1;
            disp_val = 0;
            disp_err = 0;
            an_exp = 3'b001;
            seg_exp = 7'h3F;
        end else begin
            k++;
            pos = (k / SCAN_DIV) % 3;
            an_exp = 3'(1 << pos);
            seg_exp = shown(pos, disp_val, disp_err);
            if (busy_cnt == 0) begin
                if (pending || int'(bus.value) != snap) begin
                    snap = bus.value;
                    busy_cnt = 8;
                    pending = 0;
                end
            end else begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    disp_val = snap;
                    disp_err = snap > MAX_VALUE;
                end
            end
        end
    end
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check("an", bus.an, an_exp);
            check("seg", bus.seg, seg_exp);
            check("busy", bus.busy, busy_cnt != 0);
            check("err", bus.err, disp_err);
            if (bus.busy && !prev_busy) convs++;
            prev_busy = bus.busy;
        end
    endtask
    initial begin
        bus.value = 7'd0;
        #2 reset = 1'b1;
        #1;
        check("rst_an", bus.an, 3'b001);
        check("rst_seg", bus.seg, 7'h3F);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_err", bus.err, 1'b0);
        run(3);
        reset = 1'b0;
        run(40);
        bus.value = 7'd42;
        run(40);
        bus.value = 7'd100;
        run(30);
        bus.value = 7'd101;
        run(30);
        bus.value = 7'd7;
        run(30);
        convs = 0;
        bus.value = 7'd9;
        run(1);
        bus.value = 7'd10;
        run(1);
        bus.value = 7'd11;
        run(40);
        check("skip_convs", convs, 2);
        bus.value = 7'd55;
        run(4);
        reset = 1'b1;
        #1;
        check("abort_an", bus.an, 3'b001);
        check("abort_seg", bus.seg, 7'h3F);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_err", bus.err, 1'b0);
        run(2);
        reset = 1'b0;
        run(40);
        convs = 0;
        run(100);
        check("stable_convs", convs, 0);
        repeat (300) begin
            case ($urandom_range(0, 4))
                0: bus.value = 7'(100 + $urandom_range(0, 1));
                1: bus.value = 7'(127 - $urandom_range(0, 1));
                default: bus.value = 7'($urandom_range(0, 127));
            endcase
            run($urandom_range(1, 15));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
